rsa_exp_ctrl: RTL

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_exp_ctrl_if.sv | 50 +++++
 rtl/rsa_exp_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_ctrl_if.sv
// Purpose     : request/result and Montgomery-multiplier bundle for rsa_exp_ctrl.
// Latency     : wiring only, no storage.
// Backpressure: none here; the controller ignores start while busy.
//
// Ports
//   host side      : start, in_x, in_e, in_elen, in_m, in_r, in_r2 -> result, done, busy, mm_count
//   multiplier side: mm_start, mm_a, mm_b, mm_m -> mm_result, mm_done
//   modport slave  : the exponentiation controller
//   modport master : whatever sits around it (host plus multiplier)
interface rsa_exp_ctrl_if #(
  parameter int N  = 512,
  parameter int LW = 10
);
  // host request
  logic          start;
  logic [N-1:0]  in_x;
  logic [N-1:0]  in_e;
  logic [LW-1:0] in_elen;
  logic [N-1:0]  in_m;
  logic [N-1:0]  in_r;
  logic [N-1:0]  in_r2;

  // Montgomery multiplier
  logic          mm_start;
  logic [N-1:0]  mm_a;
  logic [N-1:0]  mm_b;
  logic [N-1:0]  mm_m;
  logic [N-1:0]  mm_result;
  logic          mm_done;

  // host response / status
  logic [N-1:0]  result;
  logic          done;
  logic          busy;
  logic [15:0]   mm_count;

  modport slave (
    input  start, in_x, in_e, in_elen, in_m, in_r, in_r2,
    input  mm_result, mm_done,
    output mm_start, mm_a, mm_b, mm_m,
    output result, done, busy, mm_count
  );

  modport master (
    output start, in_x, in_e, in_elen, in_m, in_r, in_r2,
    output mm_result, mm_done,
    input  mm_start, mm_a, mm_b, mm_m,
    input  result, done, busy, mm_count
  );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// Purpose     : left-to-right binary modular exponentiation sequencer driving an external Montgomery multiplier.
// Latency     : one issue cycle plus multiplier latency per multiply, 2 + elen + popcount(e) multiplies, done one cycle after the last returns.
// Backpressure: none; start is ignored unless idle, mm_done is only honoured in the multiplier wait states.
//
// Ports
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset, returns everything to IDLE/zero
//   bus     : rsa_exp_ctrl_if.slave
//             start/in_*         sampled on the accepting edge only
//             mm_start/mm_a/b/m  one-cycle pulse, operands registered and held until mm_done
//             result/done/busy   result valid from the done cycle until the next operation finishes
//             mm_count           multiplies issued in the current or last operation (saturating)
//
// Flow: PRE converts x into the Montgomery domain (xt = x*R mod M), A starts as R mod M
// (Montgomery one), each exponent bit from MSB down squares A and multiplies by xt when
// the bit is set, POST multiplies by plain 1 to leave the Montgomery domain.
module rsa_exp_ctrl #(
  parameter int N  = 512,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  rsa_exp_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    PRE_W,
    SQR,
    SQR_W,
    MUL,
    MUL_W,
    POST,
    POST_W,
    FIN
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q;
  state_t        state_nxt;

  logic [N-1:0]  e_q;
  logic [LW-1:0] elen_q;
  logic [LW-1:0] idx_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  xt_q;
  logic [N-1:0]  mm_a_q;
  logic [N-1:0]  mm_b_q;
  logic [N-1:0]  mm_m_q;
  logic [N-1:0]  result_q;
  logic [15:0]   mm_count_q;

  logic          accept;
  logic          mm_start;
  logic          done;
  logic          busy;
  logic          idx_dec;
  logic          e_bit;
  logic          idx_zero;
  logic          elen_zero;
  logic [N-1:0]  e_mask;
  logic [N-1:0]  acc_nxt;

  assign accept    = (state_q == IDLE) && bus.start;
  assign idx_zero  = (idx_q == '0);
  assign elen_zero = (elen_q == '0);

  // Current exponent bit; a mask avoids an index wider than the operand.
  assign e_mask = ONE << idx_q;
  assign e_bit  = |(e_q & e_mask);

  // Value A will hold after this edge. Operands for the next multiply are loaded from it
  // on the same edge, so mm_a/mm_b are already valid in the mm_start cycle.
  assign acc_nxt = (bus.mm_done &&
                    (state_q == SQR_W || state_q == MUL_W || state_q == POST_W))
                   ? bus.mm_result : acc_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    idx_dec   = 1'b0;
    mm_start  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_nxt = PRE;
        end
      end
      PRE: begin
        mm_start  = 1'b1;
        state_nxt = PRE_W;
      end
      PRE_W: begin
        if (bus.mm_done) begin
          state_nxt = elen_zero ? POST : SQR;
        end
      end
      SQR: begin
        mm_start  = 1'b1;
        state_nxt = SQR_W;
      end
      SQR_W: begin
        if (bus.mm_done) begin
          if (e_bit) begin
            state_nxt = MUL;
          end else if (idx_zero) begin
            state_nxt = POST;
          end else begin
            state_nxt = SQR;
            idx_dec   = 1'b1;
          end
        end
      end
      MUL: begin
        mm_start  = 1'b1;
        state_nxt = MUL_W;
      end
      MUL_W: begin
        if (bus.mm_done) begin
          if (idx_zero) begin
            state_nxt = POST;
          end else begin
            state_nxt = SQR;
            idx_dec   = 1'b1;
          end
        end
      end
      POST: begin
        mm_start  = 1'b1;
        state_nxt = POST_W;
      end
      POST_W: begin
        if (bus.mm_done) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, accumulator, bit index, operand and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q      <= '0;
      elen_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      xt_q     <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_m_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      e_q    <= bus.in_e;
      elen_q <= bus.in_elen;
      // elen=0 never reaches SQR, so clamping keeps idx from wrapping.
      idx_q  <= (bus.in_elen == '0) ? '0 : bus.in_elen - LW'(1);
      acc_q  <= bus.in_r;
      // PRE operands: x * R^2 * R^-1 = x*R, the Montgomery form of x.
      mm_a_q <= bus.in_x;
      mm_b_q <= bus.in_r2;
      mm_m_q <= bus.in_m;
    end else begin
      acc_q <= acc_nxt;
      if (state_q == PRE_W && bus.mm_done) begin
        xt_q <= bus.mm_result;
      end
      if (idx_dec) begin
        idx_q <= idx_q - LW'(1);
      end
      case (state_nxt)
        SQR: begin
          mm_a_q <= acc_nxt;
          mm_b_q <= acc_nxt;
        end
        MUL: begin
          mm_a_q <= acc_nxt;
          mm_b_q <= xt_q;
        end
        POST: begin
          mm_a_q <= acc_nxt;
          mm_b_q <= ONE;
        end
        // result tracks A as it stands in FIN, so it is already valid while done is high.
        FIN: begin
          result_q <= acc_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_count_q <= '0;
    end else if (accept) begin
      mm_count_q <= '0;
    end else if (mm_start && mm_count_q != 16'hFFFF) begin
      mm_count_q <= mm_count_q + 16'd1;
    end
  end

  assign bus.mm_start = mm_start;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  assign bus.mm_m     = mm_m_q;
  assign bus.result   = result_q;
  assign bus.done     = done;
  assign bus.busy     = busy;
  assign bus.mm_count = mm_count_q;

endmodule
